p1p2_grant_arbiter: RTL and testbench

//  Two-requester round-robin arbiter for the shared P1/P2 pushbutton resource.

---
 rtl/p1p2_grant_arbiter.sv | 127 ++++++++++++
 tb/tb_p1p2_grant_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/p1p2_grant_arbiter.sv
// p1p2_grant_arbiter
//   Two-requester round-robin arbiter for the shared P1/P2 pushbutton resource.
//   A tenure lasts at most MAX_HOLD cycles and is always followed by GAP dead cycles.
// Ports:
//   clk        in   system clock, all state updates on posedge
//   reset      in   synchronous active-low reset
//   P1, P2     in   level requests
//   g1, g2     out  grants (Moore, decoded from the state register)
//   busy       out  1 whenever the arbiter is not idle
//   timeout    out  one-cycle pulse in the first dead cycle after a forced end
//   last_grant out  0 = P1 served last, 1 = P2 served last
module p1p2_grant_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned GAP      = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic P1,
    input  logic P2,
    output logic g1,
    output logic g2,
    output logic busy,
    output logic timeout,
    output logic last_grant
);

    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
    localparam int unsigned GapW  = $clog2(GAP + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);
    localparam logic [GapW-1:0]  GapLast  = GapW'(GAP - 1);

    typedef enum logic [1:0] {StIdle, StG1, StG2, StGapw} state_e;

    state_e           r_state;
    logic [HoldW-1:0] r_hold_cnt;
    logic [GapW-1:0]  r_gap_cnt;
    logic             r_timeout;
    logic             r_last_grant;

    state_e           w_state_nxt;
    state_e           w_arb;
    logic [HoldW-1:0] w_hold_nxt;
    logic [GapW-1:0]  w_gap_nxt;
    logic             w_timeout_nxt;
    logic             w_last_nxt;

    // Arbitration result; on a tie the side not served last wins.
    always_comb begin
        w_arb = StIdle;
        if (P1 && !P2) begin
            w_arb = StG1;
        end else if (P2 && !P1) begin
            w_arb = StG2;
        end else if (P1 && P2) begin
            w_arb = r_last_grant ? StG1 : StG2;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_gap_nxt     = r_gap_cnt;
        w_timeout_nxt = 1'b0;
        w_last_nxt    = r_last_grant;

        unique case (r_state)
            StIdle: begin
                w_state_nxt = w_arb;
            end
            StG1, StG2: begin
                if (!((r_state == StG1) ? P1 : P2)) begin
                    w_state_nxt = StGapw;
                    w_gap_nxt   = '0;
                end else if (r_hold_cnt >= HoldLast) begin
                    w_state_nxt   = StGapw;
                    w_gap_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + HoldW'(1);
                end
            end
            StGapw: begin
                // Last dead cycle arbitrates directly, no intermediate idle cycle.
                if (r_gap_cnt >= GapLast) begin
                    w_state_nxt = w_arb;
                end else begin
                    w_gap_nxt = r_gap_cnt + GapW'(1);
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // A new tenure starts only from idle or the final dead cycle.
        if ((r_state == StIdle || r_state == StGapw) && w_state_nxt == StG1) begin
            w_hold_nxt = '0;
            w_last_nxt = 1'b0;
        end else if ((r_state == StIdle || r_state == StGapw) && w_state_nxt == StG2) begin
            w_hold_nxt = '0;
            w_last_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_hold_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_timeout    <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_timeout    <= w_timeout_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    assign g1         = (r_state == StG1);
    assign g2         = (r_state == StG2);
    assign busy       = (r_state != StIdle);
    assign timeout    = r_timeout;
    assign last_grant = r_last_grant;

endmodule

// File: tb/tb_p1p2_grant_arbiter.sv
// Bench for p1p2_grant_arbiter: a default build (MAX_HOLD=8, GAP=2) and a
// MAX_HOLD=1, GAP=1 build share the same stimulus. Each is compared every
// cycle against a tenure/dead-time model written in terms of cycles served
// and dead cycles remaining.
module tb_p1p2_grant_arbiter;

    logic clk;
    logic reset;
    logic P1;
    logic P2;
    logic g1_a, g2_a, busy_a, tmo_a, last_a;
    logic g1_b, g2_b, busy_b, tmo_b, last_b;

    int total = 0;
    int bad   = 0;

    // Model state per build: 0 = default, 1 = MAX_HOLD=1/GAP=1.
    int   m_hold_max [2] = '{8, 1};
    int   m_gap      [2] = '{2, 1};
    int   m_owner    [2];  // 0 none, 1 = P1, 2 = P2
    int   m_served   [2];  // cycles granted so far in this tenure
    int   m_gap_left [2];  // dead cycles remaining, including the current one
    logic m_last     [2];
    logic m_tmo      [2];

    p1p2_grant_arbiter #(.MAX_HOLD(8), .GAP(2)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .P1         (P1),
        .P2         (P2),
        .g1         (g1_a),
        .g2         (g2_a),
        .busy       (busy_a),
        .timeout    (tmo_a),
        .last_grant (last_a)
    );

    p1p2_grant_arbiter #(.MAX_HOLD(1), .GAP(1)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .P1         (P1),
        .P2         (P2),
        .g1         (g1_b),
        .g2         (g2_b),
        .busy       (busy_b),
        .timeout    (tmo_b),
        .last_grant (last_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_step(input int i, input logic p1, input logic p2, input logic rst);
        logic tn;
        logic req;
        int   pick;
        if (!rst) begin
            m_owner[i]    = 0;
            m_served[i]   = 0;
            m_gap_left[i] = 0;
            m_last[i]     = 1'b1;
            m_tmo[i]      = 1'b0;
        end else begin
            tn = 1'b0;
            if (m_owner[i] != 0) begin
                req = (m_owner[i] == 1) ? p1 : p2;
                if (!req) begin
                    m_owner[i]    = 0;
                    m_gap_left[i] = m_gap[i];
                end else if (m_served[i] == m_hold_max[i]) begin
                    m_owner[i]    = 0;
                    m_gap_left[i] = m_gap[i];
                    tn            = 1'b1;
                end else begin
                    m_served[i]++;
                end
            end else if (m_gap_left[i] > 1) begin
                m_gap_left[i]--;
            end else begin
                m_gap_left[i] = 0;
                pick = 0;
                if (p1 && !p2) pick = 1;
                else if (p2 && !p1) pick = 2;
                else if (p1 && p2) pick = (m_last[i] == 1'b1) ? 1 : 2;
                if (pick != 0) begin
                    m_owner[i]  = pick;
                    m_served[i] = 1;
                    m_last[i]   = (pick == 2);
                end
            end
            m_tmo[i] = tn;
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        check1("a.g1",         g1_a,   m_owner[0] == 1);
        check1("a.g2",         g2_a,   m_owner[0] == 2);
        check1("a.busy",       busy_a, (m_owner[0] != 0) || (m_gap_left[0] > 0));
        check1("a.timeout",    tmo_a,  m_tmo[0]);
        check1("a.last_grant", last_a, m_last[0]);
        check1("b.g1",         g1_b,   m_owner[1] == 1);
        check1("b.g2",         g2_b,   m_owner[1] == 2);
        check1("b.busy",       busy_b, (m_owner[1] != 0) || (m_gap_left[1] > 0));
        check1("b.timeout",    tmo_b,  m_tmo[1]);
        check1("b.last_grant", last_b, m_last[1]);
        check1("a.mutex",      g1_a & g2_a, 1'b0);
        check1("b.mutex",      g1_b & g2_b, 1'b0);
    endtask

    // Drive inputs, take one edge, advance the model, then sample 1 time unit later.
    task automatic cycle(input logic p1, input logic p2, input logic rst);
        P1    = p1;
        P2    = p2;
        reset = rst;
        @(posedge clk);
        model_step(0, p1, p2, rst);
        model_step(1, p1, p2, rst);
        #1;
        check_all();
    endtask

    initial begin
        logic rp1;
        logic rp2;
        logic rrst;
        P1    = 1'b0;
        P2    = 1'b0;
        reset = 1'b0;

        // Reset with unknown requests.
        cycle(1'bx, 1'bx, 1'b0);
        cycle(1'bx, 1'bx, 1'b0);

        // T1: short sole request.
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        check1("t1.last_grant", last_a, 1'b0);

        // T2: both requesting continuously, after a fresh reset.
        cycle(1'b0, 1'b0, 1'b0);
        repeat (40) cycle(1'b1, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);

        // T3: sole requester held through several forced ends.
        repeat (25) cycle(1'b1, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);

        // T4: P2 waits behind a 4-cycle P1 tenure.
        cycle(1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);

        // T5: reset mid-tenure of G2, then a reset glitch between edges.
        repeat (2) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_all();
        repeat (6) cycle(1'b0, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);

        // Random phase: sticky request levels, occasional reset.
        rp1 = 1'b0;
        rp2 = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3, 0) == 0) rp1 = ~rp1;
            if ($urandom_range(3, 0) == 0) rp2 = ~rp2;
            rrst = ($urandom_range(49, 0) != 0);
            cycle(rp1, rp2, rrst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
